dac_code_arbiter: RTL and testbench



---
 rtl/dac_code_arbiter.sv | 104 ++++++++++
 tb/tb_dac_code_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_code_arbiter.sv
// Two-port round-robin arbiter feeding the resistor-string DAC code input.
// Accepted codes are clamped to [code_min, code_max] and then held for SETTLE cycles.
module dac_code_arbiter #(
  parameter int unsigned DW         = 10,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned RESET_CODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [DW-1:0] code_min,
  input  logic [DW-1:0] code_max,
  output logic [DW-1:0] dac_code,
  output logic          dac_update,
  output logic          busy,
  output logic          grant_id,
  output logic          clamp_hit
);

  typedef enum logic {StIdle, StSettle} state_e;

  localparam logic [DW-1:0] ResetCode  = DW'(RESET_CODE);
  localparam logic [7:0]    SettleLast = 8'(SETTLE - 1);

  state_e        state_q;
  logic [7:0]    cnt_q;
  logic          last_grant_q;

  logic          can_grant;
  logic          gnt0;
  logic          gnt1;
  logic          accept;
  logic          sel;
  logic [DW-1:0] sel_data;
  logic [DW-1:0] clamped;
  logic          clamp_now;

  always_comb begin
    // Readies are gated by rst_n so nothing can appear accepted while reset is held.
    can_grant  = rst_n && en && (state_q == StIdle);
    gnt0       = req0_valid && (!req1_valid || last_grant_q);
    gnt1       = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = can_grant && gnt0;
    req1_ready = can_grant && gnt1;
    accept     = req0_ready || req1_ready;
    sel        = req1_ready;
    sel_data   = sel ? req1_data : req0_data;
    clamp_now  = 1'b0;
    clamped    = sel_data;
    if (sel_data > code_max) begin
      clamped   = code_max;
      clamp_now = 1'b1;
    end else if (sel_data < code_min) begin
      clamped   = code_min;
      clamp_now = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;
      dac_code     <= ResetCode;
      dac_update   <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= 1'b0;
      clamp_hit    <= 1'b0;
    end else begin
      dac_update <= 1'b0;
      clamp_hit  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            dac_code     <= clamped;
            dac_update   <= 1'b1;
            clamp_hit    <= clamp_now;
            grant_id     <= sel;
            last_grant_q <= sel;
            cnt_q        <= SettleLast;
            busy         <= 1'b1;
            state_q      <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == 8'd0) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_code_arbiter.sv
// Bench for dac_code_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a cycle-accounting model.
module tb_dac_code_arbiter;

  localparam int DW     = 10;
  localparam int SETTLE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          req0_valid = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic          req1_valid = 1'b0;
  logic [DW-1:0] req1_data = '0;
  logic [DW-1:0] code_min = '0;
  logic [DW-1:0] code_max = 10'd1023;
  logic          req0_ready;
  logic          req1_ready;
  logic [DW-1:0] dac_code;
  logic          dac_update;
  logic          busy;
  logic          grant_id;
  logic          clamp_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_code_arbiter #(
    .DW(DW),
    .SETTLE(SETTLE),
    .RESET_CODE(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .code_min(code_min),
    .code_max(code_max),
    .dac_code(dac_code),
    .dac_update(dac_update),
    .busy(busy),
    .grant_id(grant_id),
    .clamp_hit(clamp_hit)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampf(input int d, input int mn, input int mx);
    if (d > mx) return mx;
    if (d < mn) return mn;
    return d;
  endfunction

  // Model: an accept in cycle c makes the block busy for cycles c+1..c+SETTLE.
  int m_cyc;
  int m_busy_until;
  int m_code;
  int m_gid;
  int m_last;
  int m_upd;
  int m_clamp;

  always @(negedge clk) begin
    int g;
    int d;
    if (!rst_n) begin
      chk("rst_ready0", int'(req0_ready), 0);
      chk("rst_ready1", int'(req1_ready), 0);
      chk("rst_code", int'(dac_code), 0);
      chk("rst_update", int'(dac_update), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_gid", int'(grant_id), 0);
      chk("rst_clamp", int'(clamp_hit), 0);
      m_cyc = 0; m_busy_until = -1; m_code = 0; m_gid = 0; m_last = 1;
      m_upd = 0; m_clamp = 0;
    end else begin
      g = -1;
      if (m_cyc > m_busy_until && en) begin
        if (req0_valid && req1_valid) g = 1 - m_last;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
      end
      chk("m_ready0", int'(req0_ready), int'(g == 0));
      chk("m_ready1", int'(req1_ready), int'(g == 1));
      chk("m_busy", int'(busy), int'(m_cyc <= m_busy_until));
      chk("m_code", int'(dac_code), m_code);
      chk("m_update", int'(dac_update), m_upd);
      chk("m_gid", int'(grant_id), m_gid);
      chk("m_clamp", int'(clamp_hit), m_clamp);
      m_upd = 0;
      m_clamp = 0;
      if (g >= 0) begin
        d = (g == 1) ? int'(req1_data) : int'(req0_data);
        m_code = clampf(d, int'(code_min), int'(code_max));
        m_clamp = int'(m_code != d);
        m_gid = g;
        m_last = g;
        m_upd = 1;
        m_busy_until = m_cyc + SETTLE;
      end
      m_cyc++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("idle_wait", int'(busy), 0);
  endtask

  // Present a code on port p until it is accepted; returns just after the accepting edge.
  task automatic write(input int p, input int d);
    bit ok;
    ok = 1'b0;
    if (p == 0) begin req0_valid = 1'b1; req0_data = DW'(d); end
    else begin req1_valid = 1'b1; req1_data = DW'(d); end
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if ((p == 0) ? req0_ready : req1_ready) ok = 1'b1;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("handshake", int'(ok), 1);
  endtask

  initial begin
    int codes[4];
    int gids[4];
    int when[4];
    int n;
    int cyc;

    // Reset held with a valid request present.
    en = 1'b1; req0_valid = 1'b1; req0_data = 10'd55;
    repeat (3) tick();
    #1;
    chk("hold_ready0", int'(req0_ready), 0);
    chk("hold_code", int'(dac_code), 0);
    chk("hold_busy", int'(busy), 0);

    // Single port: first accept right after release.
    req0_data = 10'd300;
    rst_n = 1'b1;
    #1;
    chk("first_ready0", int'(req0_ready), 1);
    tick();
    chk("w300_code", int'(dac_code), 300);
    chk("w300_update", int'(dac_update), 1);
    chk("w300_busy", int'(busy), 1);
    req0_data = 10'd700;
    #1;
    chk("busy_ready0", int'(req0_ready), 0);
    repeat (3) tick();
    chk("t4_busy", int'(busy), 1);
    chk("t4_code", int'(dac_code), 300);
    tick();
    chk("t5_busy", int'(busy), 0);
    chk("t5_update", int'(dac_update), 0);
    #1;
    chk("t5_ready0", int'(req0_ready), 1);
    tick();
    chk("w700_code", int'(dac_code), 700);
    chk("w700_update", int'(dac_update), 1);
    req0_valid = 1'b0;

    // Contention from a fresh reset.
    do_reset();
    req0_valid = 1'b1; req0_data = 10'd100;
    req1_valid = 1'b1; req1_data = 10'd200;
    n = 0;
    cyc = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      tick();
      cyc++;
      if (dac_update) begin
        codes[n] = int'(dac_code);
        gids[n] = int'(grant_id);
        when[n] = cyc;
        n++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("cont_count", n, 4);
    for (int i = 0; i < n; i++) begin
      chk("cont_code", codes[i], (i % 2 == 0) ? 100 : 200);
      chk("cont_gid", gids[i], i % 2);
      if (i > 0) chk("cont_gap", when[i] - when[i-1], SETTLE + 1);
    end

    // Clamp window, normal and inverted.
    code_min = 10'd64; code_max = 10'd960;
    write(0, 1000); chk("c1000", int'(dac_code), 960); chk("c1000_hit", int'(clamp_hit), 1);
    write(0, 10);   chk("c10", int'(dac_code), 64);    chk("c10_hit", int'(clamp_hit), 1);
    write(0, 500);  chk("c500", int'(dac_code), 500);  chk("c500_hit", int'(clamp_hit), 0);
    code_min = 10'd900; code_max = 10'd100;
    write(1, 50);   chk("inv50", int'(dac_code), 900);
    write(1, 950);  chk("inv950", int'(dac_code), 100);
    chk("inv950_gid", int'(grant_id), 1);
    code_min = 10'd0; code_max = 10'd1023;

    // Enable low blocks grants.
    wait_idle();
    en = 1'b0;
    req1_valid = 1'b1; req1_data = 10'd333;
    repeat (3) begin
      #1;
      chk("en0_ready1", int'(req1_ready), 0);
      tick();
      chk("en0_code", int'(dac_code), 100);
    end
    en = 1'b1;
    write(1, 333);
    chk("w333_code", int'(dac_code), 333);
    // Drop en mid-hold and pulse a withdrawn req0.
    en = 1'b0;
    tick();
    req0_valid = 1'b1; req0_data = 10'd5;
    tick();
    req0_valid = 1'b0;
    wait_idle();
    chk("en_drop_code", int'(dac_code), 333);
    repeat (2) tick();
    chk("withdraw_code", int'(dac_code), 333);
    en = 1'b1;

    // Async reset mid-hold.
    write(0, 400);
    tick();
    chk("pre_rst_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_code", int'(dac_code), 0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 10'd77;
    #1;
    chk("post_rst_ready0", int'(req0_ready), 1);
    tick();
    chk("post_rst_code", int'(dac_code), 77);
    req0_valid = 1'b0;

    // Random traffic; the negedge model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 599) != 0);
      en = ($urandom_range(0, 7) != 0);
      req0_valid = $urandom_range(0, 1) == 1;
      req1_valid = $urandom_range(0, 1) == 1;
      req0_data = ($urandom_range(0, 9) == 0) ? code_max : DW'($urandom_range(0, 1023));
      req1_data = ($urandom_range(0, 9) == 0) ? code_min : DW'($urandom_range(0, 1023));
      if ($urandom_range(0, 49) == 0) begin
        code_min = DW'($urandom_range(0, 600));
        code_max = DW'($urandom_range(300, 1023));
      end
    end

    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (8) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
